// File: rtl/fft_out_seq.sv
// Result unloader: reads a completed FFT frame from RAM in bin order and streams it
// out through a 2-entry buffer, optionally conjugating and 1/N scaling for inverse mode.
module fft_out_seq #(
  parameter int DW        = 16,
  parameter int AW        = 9,
  parameter int LOG2_NMIN = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [1:0]    np_i,
  input  logic          inv_i,
  input  logic          scale_en_i,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [DW-1:0] rd_re_i,
  input  logic [DW-1:0] rd_im_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_re_o,
  output logic [DW-1:0] m_im_o,
  output logic [AW-1:0] m_idx_o,
  output logic          m_sop_o,
  output logic          m_eop_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int MW = $clog2(AW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [AW-1:0] idx;
    logic          sop;
    logic          eop;
  } ent_t;

  state_t        state_q;
  logic [1:0]    np_q;
  logic          inv_q, sc_q, done_q;
  logic [AW-1:0] addr_q, ra_q;
  logic          infl_q;
  ent_t          fifo_q [2];
  logic          wp_q, rp_q;
  logic [1:0]    cnt_q;

  logic [MW-1:0] m_w;
  logic [AW:0]   nm1_w;
  logic [AW-1:0] last_w;
  logic          pop, start_acc, credit, issue;
  ent_t          hd, wr_ent;

  logic signed [DW-1:0] re_s, im_s, im_c, re_x, im_x;

  assign m_w    = MW'(LOG2_NMIN) + MW'(np_q);
  assign nm1_w  = ((AW+1)'(1) << m_w) - (AW+1)'(1);
  assign last_w = nm1_w[AW-1:0];

  assign hd        = fifo_q[rp_q];
  assign m_valid_o = (cnt_q != 2'd0);
  assign pop       = m_valid_o && m_ready_i;
  // A start landing on the done cycle belongs to the frame just closed and is dropped.
  assign start_acc = (state_q == IDLE) && start_i && !done_q;
  // Never let buffered + in-flight samples exceed the two FIFO slots.
  assign credit    = ({1'b0, cnt_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
  assign issue     = credit && (start_acc || (state_q == RUN));

  assign rd_en_o   = issue;
  assign rd_addr_o = issue ? addr_q : '0;

  assign m_re_o  = m_valid_o ? hd.re  : '0;
  assign m_im_o  = m_valid_o ? hd.im  : '0;
  assign m_idx_o = m_valid_o ? hd.idx : '0;
  assign m_sop_o = m_valid_o && hd.sop;
  assign m_eop_o = m_valid_o && hd.eop;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;

  always_comb begin
    re_s = $signed(rd_re_i);
    im_s = $signed(rd_im_i);
    im_c = im_s;
    if (inv_q) begin
      if (im_s == {1'b1, {(DW-1){1'b0}}}) im_c = {1'b0, {(DW-1){1'b1}}};
      else                                im_c = -im_s;
    end
    re_x = re_s;
    im_x = im_c;
    if (inv_q && sc_q) begin
      re_x = re_s >>> m_w;
      im_x = im_c >>> m_w;
    end
    wr_ent.re  = re_x;
    wr_ent.im  = im_x;
    wr_ent.idx = ra_q;
    wr_ent.sop = (ra_q == '0);
    wr_ent.eop = (ra_q == last_w);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      np_q    <= '0;
      inv_q   <= 1'b0;
      sc_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      ra_q    <= '0;
      infl_q  <= 1'b0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      infl_q <= issue;
      if (issue) begin
        ra_q   <= addr_q;
        addr_q <= addr_q + AW'(1);
      end
      if (infl_q) wp_q <= ~wp_q;
      if (pop)    rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
      case (state_q)
        IDLE: if (start_acc) begin
          np_q    <= np_i;
          inv_q   <= inv_i;
          sc_q    <= scale_en_i;
          state_q <= RUN;
        end
        RUN: if (issue && (addr_q == last_w)) begin
          addr_q  <= '0;
          state_q <= DRAIN;
        end
        DRAIN: if (pop && hd.eop) begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage only; occupancy and pointers above decide what is visible.
  always_ff @(posedge clk_i) begin
    if (infl_q) fifo_q[wp_q] <= wr_ent;
  end

endmodule

// File: tb/tb_fft_out_seq.sv
// Randomized scoreboard bench for fft_out_seq with a behavioural RAM and sample model.
module tb_fft_out_seq;
  localparam int DW = 16, AW = 9, LN = 6;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0] np = '0;
  logic inv = 1'b0, sc = 1'b0, m_ready = 1'b1;
  logic rd_en, m_valid, sop, eop, busy, done;
  logic [AW-1:0] rd_addr, m_idx;
  logic [DW-1:0] rd_re = '0, rd_im = '0, m_re, m_im;

  logic [DW-1:0] ram_re [512];
  logic [DW-1:0] ram_im [512];

  typedef struct {int re; int im; int idx; bit sop; bit eop;} exp_t;
  exp_t q[$];

  int checks = 0, passed = 0;
  int acc_cnt = 0, rd_cnt = 0, done_cnt = 0, outst = 0, rd_exp = 0;
  bit rmode = 0;
  int cap_re [512];
  int cap_im [512];

  fft_out_seq #(.DW(DW), .AW(AW), .LOG2_NMIN(LN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .np_i(np), .inv_i(inv),
    .scale_en_i(sc), .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_re_i(rd_re),
    .rd_im_i(rd_im), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_re_o(m_re),
    .m_im_o(m_im), .m_idx_o(m_idx), .m_sop_o(sop), .m_eop_o(eop),
    .busy_o(busy), .done_o(done));

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) begin
    rd_re <= ram_re[rd_addr];
    rd_im <= ram_im[rd_addr];
  end

  always @(posedge clk) begin
    #1;
    if (rmode) m_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input bit ok, input string name, input string detail);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic int floor_div2(input int v, input int m);
    int d;
    d = 1 << m;
    return (v >= 0) ? v / d : -((-v + d - 1) / d);
  endfunction

  task automatic push_frame(input int npv, input bit iv, input bit s);
    int n, m, re, im;
    exp_t e;
    m = LN + npv;
    n = 1 << m;
    for (int k = 0; k < n; k++) begin
      re = int'($signed(ram_re[k]));
      im = int'($signed(ram_im[k]));
      if (iv) im = (im == -32768) ? 32767 : -im;
      if (iv && s) begin
        re = floor_div2(re, m);
        im = floor_div2(im, m);
      end
      e.re = re; e.im = im; e.idx = k; e.sop = (k == 0); e.eop = (k == n - 1);
      q.push_back(e);
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 512; k++) begin
      ram_re[k] = 16'($urandom);
      ram_im[k] = 16'($urandom);
    end
  endtask

  task automatic start_pulse(input int npv, input bit iv, input bit s);
    @(posedge clk); #1;
    start = 1'b1; np = 2'(npv); inv = iv; sc = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((q.size() != 0 || busy) && n < 8000) begin
      @(posedge clk); #1; n++;
    end
    chk(n < 8000, name, $sformatf("timeout, %0d samples still expected", q.size()));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input string name);
    int n = 0;
    while (acc_cnt < target && n < 4000) begin
      @(posedge clk); #1; n++;
    end
    chk(n < 4000, name, $sformatf("timeout waiting for %0d accepts, have %0d", target, acc_cnt));
  endtask

  logic [DW-1:0] p_re, p_im;
  logic [AW-1:0] p_idx;
  logic p_sop, p_eop;
  bit have_prev = 0;

  always @(negedge clk) begin
    exp_t e;
    bit pop;
    if (!rst_n) begin
      outst = 0; have_prev = 0;
    end else begin
      pop = m_valid && m_ready;
      if (rd_en) begin
        if (!busy) rd_exp = 0;
        chk(int'(rd_addr) == rd_exp, "rd_addr_order", $sformatf("got %0d want %0d", rd_addr, rd_exp));
        rd_exp++; rd_cnt++;
      end else if (rd_addr != '0) begin
        chk(1'b0, "rd_addr_idle", $sformatf("got %0d want 0", rd_addr));
      end
      outst = outst + int'(rd_en) - int'(pop);
      if (rd_en) chk(outst <= 2, "credit", $sformatf("outstanding %0d, limit 2", outst));
      if (have_prev)
        chk(m_valid && m_re == p_re && m_im == p_im && m_idx == p_idx && sop == p_sop && eop == p_eop,
            "stall_stable", $sformatf("got v%0d %h %h i%0d, held %h %h i%0d", m_valid, m_re, m_im, m_idx, p_re, p_im, p_idx));
      have_prev = m_valid && !m_ready;
      p_re = m_re; p_im = m_im; p_idx = m_idx; p_sop = sop; p_eop = eop;
      if (!m_valid && (m_re != '0 || m_im != '0 || m_idx != '0 || sop || eop))
        chk(1'b0, "idle_zero", $sformatf("got %h %h i%0d s%0d e%0d", m_re, m_im, m_idx, sop, eop));
      if (pop) begin
        if (q.size() == 0) chk(1'b0, "unexpected", $sformatf("sample idx %0d with empty scoreboard", m_idx));
        else begin
          e = q.pop_front();
          chk(int'($signed(m_re)) == e.re && int'($signed(m_im)) == e.im && int'(m_idx) == e.idx &&
              sop == e.sop && eop == e.eop, "sample",
              $sformatf("got (%0d,%0d) i%0d s%0d e%0d want (%0d,%0d) i%0d s%0d e%0d",
                        $signed(m_re), $signed(m_im), m_idx, sop, eop, e.re, e.im, e.idx, e.sop, e.eop));
        end
        cap_re[m_idx] = int'($signed(m_re));
        cap_im[m_idx] = int'($signed(m_im));
        acc_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, a0, r0, consec;
    fill_rand();
    #1;
    chk(!rd_en && rd_addr == '0, "rst_rd", $sformatf("rd_en %0d addr %0d want 0 0", rd_en, rd_addr));
    chk(!m_valid && m_re == '0 && m_im == '0 && m_idx == '0, "rst_m", $sformatf("v%0d %h %h i%0d want 0", m_valid, m_re, m_im, m_idx));
    chk(!sop && !eop, "rst_sopeop", $sformatf("sop %0d eop %0d want 0 0", sop, eop));
    chk(!busy && !done, "rst_busy", $sformatf("busy %0d done %0d want 0 0", busy, done));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ramp frame, full throughput
    for (int k = 0; k < 64; k++) begin
      ram_re[k] = 16'(k);
      ram_im[k] = 16'(-k);
    end
    d0 = done_cnt;
    push_frame(0, 0, 0);
    start_pulse(0, 0, 0);
    @(negedge clk);
    chk(!m_valid, "latency_1", $sformatf("m_valid %0d one cycle after start, want 0", m_valid));
    @(negedge clk);
    chk(m_valid, "latency_2", $sformatf("m_valid %0d two cycles after start, want 1", m_valid));
    consec = 1;
    repeat (63) begin
      @(negedge clk);
      if (m_valid) consec++;
    end
    chk(consec == 64, "consecutive", $sformatf("%0d of 64 cycles valid", consec));
    wait_idle("ramp_frame");
    chk(done_cnt == d0 + 1, "done_once", $sformatf("done pulses %0d want 1", done_cnt - d0));
    chk(!busy, "busy_low", $sformatf("busy %0d want 0", busy));

    // inverse with scaling, saturation corner
    fill_rand();
    ram_re[0] = 16'h7F00; ram_im[0] = 16'h8000;
    ram_re[1] = 16'hFFFF; ram_im[1] = 16'h0080;
    push_frame(1, 1, 1);
    start_pulse(1, 1, 1);
    wait_idle("inv_scale");
    chk(cap_re[0] == 254 && cap_im[0] == 255, "inv_idx0", $sformatf("got (%0d,%0d) want (254,255)", cap_re[0], cap_im[0]));
    chk(cap_re[1] == -1 && cap_im[1] == -1, "inv_idx1", $sformatf("got (%0d,%0d) want (-1,-1)", cap_re[1], cap_im[1]));

    // largest frame with random backpressure, then mixed random frames
    fill_rand();
    rmode = 1;
    a0 = acc_cnt;
    push_frame(3, 0, 0);
    start_pulse(3, 0, 0);
    wait_idle("np3_random");
    chk(acc_cnt - a0 == 512, "np3_count", $sformatf("accepted %0d want 512", acc_cnt - a0));
    for (int f = 0; f < 3; f++) begin
      int npv;
      bit iv, s;
      npv = $urandom_range(0, 2); iv = 1'($urandom); s = 1'($urandom);
      fill_rand();
      push_frame(npv, iv, s);
      start_pulse(npv, iv, s);
      wait_idle("rand_frame");
    end
    rmode = 0;
    m_ready = 1'b1;

    // start during a running frame is ignored
    fill_rand();
    a0 = acc_cnt;
    push_frame(2, 0, 0);
    start_pulse(2, 0, 0);
    wait_acc(a0 + 20, "restart_wait");
    start_pulse(0, 1, 1);
    wait_idle("restart_ignored");
    chk(acc_cnt - a0 == 256, "restart_count", $sformatf("accepted %0d want 256", acc_cnt - a0));
    repeat (4) @(posedge clk);
    #1;
    chk(!m_valid && !busy, "restart_no_frame", $sformatf("m_valid %0d busy %0d want 0 0", m_valid, busy));

    // reset mid-frame while stalled
    fill_rand();
    a0 = acc_cnt;
    d0 = done_cnt;
    push_frame(0, 0, 0);
    start_pulse(0, 0, 0);
    wait_acc(a0 + 30, "reset_wait");
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk(!rd_en && rd_addr == '0 && !m_valid && m_re == '0 && m_im == '0 && m_idx == '0 &&
        !sop && !eop && !busy && !done, "reset_outputs",
        $sformatf("rd %0d v%0d %h %h i%0d busy %0d done %0d want all 0", rd_en, m_valid, m_re, m_im, m_idx, busy, done));
    q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk(done_cnt == d0, "reset_no_done", $sformatf("done pulses %0d want 0", done_cnt - d0));
    fill_rand();
    a0 = acc_cnt;
    push_frame(0, 0, 0);
    start_pulse(0, 0, 0);
    wait_idle("post_reset");
    chk(acc_cnt - a0 == 64, "post_reset_count", $sformatf("accepted %0d want 64", acc_cnt - a0));

    // 10-cycle stall at idx 5
    fill_rand();
    a0 = acc_cnt;
    push_frame(0, 1, 0);
    start_pulse(0, 1, 0);
    wait_acc(a0 + 5, "stall_wait");
    m_ready = 1'b0;
    r0 = rd_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk(rd_cnt - r0 <= 2, "stall_reads", $sformatf("%0d reads during stall, limit 2", rd_cnt - r0));
    chk(outst == 2, "stall_outstanding", $sformatf("outstanding %0d want 2", outst));
    chk(m_valid && int'(m_idx) == 5, "stall_head", $sformatf("v%0d idx %0d want 1 5", m_valid, m_idx));
    m_ready = 1'b1;
    consec = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid) consec++;
    end
    chk(consec == 20, "stall_resume", $sformatf("%0d of 20 cycles valid after release", consec));
    wait_idle("stall_frame");
    chk(acc_cnt - a0 == 64, "stall_count", $sformatf("accepted %0d want 64", acc_cnt - a0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
